// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller: runs a req/ack bus transaction for
// loads/stores and holds the pipeline until the result is presented to MEM/WB.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        align_err_o
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             bus_err_q, bus_err_d;
    logic             align_err_q, align_err_d;
    logic             acc;

    assign acc = memread_i | memwrite_i;

    // Hold the pipeline from the request cycle until the DONE cycle.
    assign stall_o = ((state_q == ST_IDLE) & acc) | (state_q == ST_BUSY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        bus_err_d   = bus_err_q;
        align_err_d = align_err_q;

        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (addr_i[1:0] == 2'b00) begin
                        state_d     = ST_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = memwrite_i;
                        mem_addr_d  = addr_i;
                        mem_wdata_d = wdata_i;
                        cnt_d       = '0;
                    end else begin
                        state_d     = ST_DONE;
                        align_err_d = 1'b1;
                        rdata_d     = '0;
                    end
                end
            end
            ST_BUSY: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack_i) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    rdata_d   = mem_we_q ? 32'd0 : mem_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                bus_err_d   = 1'b0;
                align_err_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rdata_o     = rdata_q;
    assign bus_err_o   = bus_err_q;
    assign align_err_o = align_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected completions are queued when an
// access is launched and compared when the DONE cycle appears.
module tb_mem_stage_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        memread_i = 1'b0;
    logic        memwrite_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        bus_err_o;
    logic        align_err_o;

    typedef struct {
        logic [31:0] rdata;
        logic        berr;
        logic        aerr;
        int          stalls;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .memread_i  (memread_i),
        .memwrite_i (memwrite_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i  (mem_ack_i),
        .mem_rdata_i(mem_rdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .bus_err_o  (bus_err_o),
        .align_err_o(align_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Launch one access from IDLE; ack_at is the 0-based BUSY cycle carrying ack, -1 = none.
    // Returns one cycle after DONE, back in IDLE, with the request inputs still held.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rdv);
        exp_t e;
        exp_t got;
        logic [1:0] lo;
        int stalls;
        int busy;
        bit done;
        lo = a[1:0];
        e.aerr   = (lo != 2'b00);
        e.berr   = !e.aerr && (ack_at < 0);
        e.rdata  = (e.aerr || wr || ack_at < 0) ? 32'd0 : rdv;
        e.busy   = e.aerr ? 0 : ((ack_at < 0) ? int'(TIMEOUT) : ack_at + 1);
        e.stalls = 1 + e.busy;
        exp_q.push_back(e);

        memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
        stalls = 0; busy = 0; done = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!stall_o) begin
                done = 1;
                break;
            end
            stalls++;
            if (mem_req_o) begin
                n_total++;
                if (mem_addr_o !== a || mem_wdata_o !== wd || mem_we_o !== wr)
                    $display("FAIL %s busy_bus: addr=%h wdata=%h we=%b required addr=%h wdata=%h we=%b",
                             name, mem_addr_o, mem_wdata_o, mem_we_o, a, wd, wr);
                else n_pass++;
                mem_ack_i   = (busy == ack_at);
                mem_rdata_i = rdv;
                busy++;
            end else begin
                mem_ack_i = 1'b0;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end

        n_total++;
        if (!done) begin
            $display("FAIL %s done_timeout: stall_o never dropped within 64 cycles, required DONE", name);
            void'(exp_q.pop_front());
            return;
        end
        n_pass++;
        got = exp_q.pop_front();

        n_total++;
        if (rdata_o !== got.rdata || bus_err_o !== got.berr || align_err_o !== got.aerr || mem_req_o !== 1'b0)
            $display("FAIL %s done_out: rdata=%h berr=%b aerr=%b req=%b required rdata=%h berr=%b aerr=%b req=0",
                     name, rdata_o, bus_err_o, align_err_o, mem_req_o, got.rdata, got.berr, got.aerr);
        else n_pass++;

        n_total++;
        if (stalls != got.stalls || busy != got.busy)
            $display("FAIL %s latency: stalls=%0d busy=%0d required stalls=%0d busy=%0d",
                     name, stalls, busy, got.stalls, got.busy);
        else n_pass++;

        // DONE must fall back to IDLE even with the request still asserted.
        @(posedge clk_i); #1;
        n_total++;
        if (mem_req_o !== 1'b0 || bus_err_o !== 1'b0 || align_err_o !== 1'b0 || stall_o !== 1'b1 ||
            rdata_o !== got.rdata)
            $display("FAIL %s after_done: req=%b berr=%b aerr=%b stall=%b rdata=%h required 0 0 0 1 %h",
                     name, mem_req_o, bus_err_o, align_err_o, stall_o, rdata_o, got.rdata);
        else n_pass++;
    endtask

    task automatic go_idle();
        memread_i = 1'b0; memwrite_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        memread_i = 1'b1; addr_i = 32'h44;
        repeat (2) @(posedge clk_i);
        #1;
        memread_i = 1'b0;
        #1;
        n_total++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0 ||
            rdata_o !== 32'd0 || bus_err_o !== 1'b0 || align_err_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL reset: req=%b we=%b addr=%h wdata=%h rdata=%h berr=%b aerr=%b stall=%b required all 0",
                     mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, bus_err_o, align_err_o, stall_o);
        else n_pass++;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_zero_wait_load();
        do_access("zero_wait_load", 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEBABE);
        go_idle();
    endtask

    task automatic test_store_wait();
        do_access("store_3wait", 1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'hDEAD0000);
        go_idle();
    endtask

    task automatic test_timeout();
        do_access("timeout", 1'b1, 1'b0, 32'h40, 32'h0, -1, 32'h55555555);
        go_idle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
        repeat (2) begin
            @(posedge clk_i); #1;
            n_total++;
            if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'd0 || bus_err_o !== 1'b0)
                $display("FAIL late_ack: req=%b stall=%b rdata=%h berr=%b required 0 0 0 0",
                         mem_req_o, stall_o, rdata_o, bus_err_o);
            else n_pass++;
        end
        mem_ack_i = 1'b0;
    endtask

    task automatic test_misaligned();
        do_access("misaligned", 1'b1, 1'b0, 32'h102, 32'h0, -1, 32'h0);
        go_idle();
    endtask

    task automatic test_back_to_back();
        do_access("b2b_first", 1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h11111111);
        do_access("b2b_second", 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h22222222);
        do_access("rd_wr_both", 1'b1, 1'b1, 32'h300, 32'hAAAA5555, 0, 32'h33333333);
        go_idle();
        do_access("load_after", 1'b1, 1'b0, 32'h304, 32'h0, 2, 32'h0BADF00D);
        go_idle();
    endtask

    task automatic test_reset_mid();
        memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 32'h80;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        n_total++;
        if (mem_req_o !== 1'b1 || stall_o !== 1'b1)
            $display("FAIL rst_mid_busy: req=%b stall=%b required 1 1", mem_req_o, stall_o);
        else n_pass++;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        #1;
        n_total++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b1 || rdata_o !== 32'd0 || mem_addr_o !== 32'd0)
            $display("FAIL rst_mid_idle: req=%b stall=%b rdata=%h addr=%h required 0 1 0 0",
                     mem_req_o, stall_o, rdata_o, mem_addr_o);
        else n_pass++;
        memread_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        n_total++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'd0 || bus_err_o !== 1'b0)
            $display("FAIL rst_mid_ack: req=%b stall=%b rdata=%h berr=%b required 0 0 0 0",
                     mem_req_o, stall_o, rdata_o, bus_err_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_timeout();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage data-memory access controller: the producer side of the MEM/WB pipeline interface.
- Takes the load/store request from the EX/MEM register and runs a req/ack transaction on the external data-memory bus.
- Drives stall_o, which the pipeline wires to keep_i on every pipeline register while an access is outstanding.
- Presents load data on rdata_o, which feeds data_mem_i of the MEM/WB register, in the single cycle the stall is released.

Parameters:
TIMEOUT, 16, number of BUSY cycles without mem_ack_i before the access is aborted; legal range 1..255.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
memread_i  in  1  load request from EX/MEM
memwrite_i  in  1  store request from EX/MEM
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data
mem_req_o  out  1  bus request, registered
mem_we_o  out  1  bus write enable, registered
mem_addr_o  out  32  bus address, registered
mem_wdata_o  out  32  bus write data, registered
mem_ack_i  in  1  bus completion strobe
mem_rdata_i  in  32  bus read data, valid with mem_ack_i
rdata_o  out  32  load result to MEM/WB data_mem_i, registered
stall_o  out  1  pipeline hold, combinational from state and inputs
bus_err_o  out  1  timeout error flag, valid in DONE only
align_err_o  out  1  misaligned-access flag, valid in DONE only

Behaviour:
- Reset (rst_i=1 at a clock edge), from any state including mid-transaction:
  - state=IDLE; counter=0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - rdata_o=0, bus_err_o=0, align_err_o=0.
  - Any in-flight transaction is abandoned; a later mem_ack_i is ignored.
- FSM states: IDLE, BUSY, DONE.
- acc = memread_i | memwrite_i. If both are set, the access is a write (memwrite_i wins).
- stall_o = (IDLE & acc) | BUSY. stall_o is 0 in DONE.
- IDLE, acc=1, addr_i[1:0]==0:
  - Next cycle: state=BUSY, mem_req_o=1, mem_we_o=memwrite_i.
  - mem_addr_o=addr_i and mem_wdata_o=wdata_i are latched; counter=0.
- IDLE, acc=1, addr_i[1:0]!=0:
  - No bus access is issued.
  - Next cycle: state=DONE, align_err_o=1, rdata_o=0.
- IDLE, acc=0: stay in IDLE; outputs hold.
- BUSY, mem_ack_i=1:
  - Next cycle: state=DONE, mem_req_o=0, mem_we_o=0.
  - Read: rdata_o=mem_rdata_i. Write: rdata_o=0.
- BUSY, mem_ack_i=0:
  - counter increments.
  - When counter==TIMEOUT-1 with still no ack: next state=DONE, mem_req_o=0, bus_err_o=1, rdata_o=0.
  - If ack and timeout fall in the same cycle, ack wins (normal completion, no error).
- DONE:
  - Lasts exactly 1 cycle. The pipeline advances at its closing edge and MEM/WB captures rdata_o.
  - acc is ignored in DONE (it is still the same instruction). Next state=IDLE.
  - bus_err_o and align_err_o clear when leaving DONE.
- mem_ack_i outside BUSY is spurious and ignored. mem_req_o is asserted only from BUSY, so an ack can never complete in the cycle the request was launched from IDLE.
- mem_addr_o and mem_wdata_o stay stable for the whole of BUSY.
- rdata_o holds its value outside DONE until the next completion.
- Latency:
  - Zero-wait memory (ack in the first BUSY cycle): 2 stall cycles, then DONE.
  - General: stall = 1 + (BUSY cycles).
  - Misaligned access: 1 stall cycle.

Test Plan:
- Zero-wait load: addr=0x100, memread=1, mem_ack_i=1 with rdata=0xCAFEBABE in the first BUSY cycle -> stall_o=1 for 2 cycles; mem_req_o=1 with mem_addr_o=0x100 for 1 cycle; DONE shows rdata_o=0xCAFEBABE with stall_o=0; next cycle is IDLE.
- Store with 3 wait states: addr=0x20, wdata=0x12345678 -> mem_we_o=1 and mem_wdata_o stable for 4 BUSY cycles; 5 stall cycles total; rdata_o=0 in DONE; no error flags.
- Timeout with TIMEOUT=4, no ack -> BUSY lasts 4 cycles; DONE has bus_err_o=1, rdata_o=0, mem_req_o=0; a late ack in IDLE is ignored.
- Misaligned load at addr=0x102 -> mem_req_o never asserted; 1 stall cycle; DONE has align_err_o=1.
- Back-to-back loads held on the inputs, plus simultaneous memread/memwrite -> DONE does not retrigger the access; the second access starts from IDLE; the simultaneous request issues a write.
- rst_i pulsed in the 2nd BUSY cycle -> next cycle IDLE with mem_req_o=0, stall_o=acc, rdata_o=0; a subsequent ack is ignored.
